decoder_scan_nx2n: RTL and testbench



---
 rtl/decoder_scan_nx2n_pkg.sv | 17 +
 rtl/decoder_scan_nx2n_scan_prescaler.sv | 31 +++
 rtl/decoder_scan_nx2n.sv | 89 ++++++++
 tb/tb_decoder_scan_nx2n.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/decoder_scan_nx2n_pkg.sv
// Shared encodings and helpers for the scanned N-to-2^N select decoder.
package decoder_scan_nx2n_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic {
    ST_DIRECT = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  // Prescaler width: max(1, clog2(div)).
  function automatic int unsigned presc_width(input int unsigned div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/decoder_scan_nx2n_scan_prescaler.sv
// Divide-by-DIV enabled-cycle prescaler; tick marks the terminal count.
module scan_prescaler
  import decoder_scan_nx2n_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned W    = presc_width(DIV);
  localparam logic [W-1:0] TERM = W'(DIV - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == TERM) ? '0 : r_cnt + W'(1);
    end
  end

  assign tick = en && (r_cnt == TERM);

endmodule

// File: rtl/decoder_scan_nx2n.sv
// Registered N-to-2^N one-hot select with direct-load and auto-scan modes.
module decoder_scan_nx2n
  import decoder_scan_nx2n_pkg::*;
#(
  parameter int unsigned N          = 2,
  parameter int unsigned DIV        = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic                load,
  input  logic [N-1:0]        sel,
  output logic [(1<<N)-1:0]   o,
  output logic [N-1:0]        idx,
  output logic                wrap
);

  localparam int unsigned      LINES    = 1 << N;
  localparam logic [N-1:0]     IDX_MAX  = {N{1'b1}};
  localparam logic [LINES-1:0] INACTIVE = {LINES{ACTIVE_LOW}};

  state_t           r_state;
  logic [N-1:0]     r_idx;
  logic [LINES-1:0] r_o;
  logic             r_wrap;

  logic             w_presc_en;
  logic             w_presc_clr;
  logic             w_tick;
  logic             w_step;
  logic             w_wrap_next;
  logic [N-1:0]     w_idx_next;
  logic [LINES-1:0] w_onehot;

  // Prescaler runs only in SCAN; a load or a fresh entry into SCAN restarts the dwell.
  assign w_presc_en  = en && (r_state == ST_SCAN);
  assign w_presc_clr = en && (load || ((r_state == ST_DIRECT) && (mode == MODE_SCAN)));

  scan_prescaler #(
    .DIV (DIV)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .en   (w_presc_en),
    .clr  (w_presc_clr),
    .tick (w_tick)
  );

  assign w_step      = w_tick && !load;
  assign w_wrap_next = w_step && (r_idx == IDX_MAX);

  always_comb begin
    w_idx_next = r_idx;
    if (load) begin
      w_idx_next = sel;
    end else if (w_step) begin
      w_idx_next = r_idx + N'(1);
    end
  end

  for (genvar i = 0; i < LINES; i++) begin : g_line
    assign w_onehot[i] = (w_idx_next == N'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_DIRECT;
      r_idx   <= '0;
      r_o     <= INACTIVE;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= w_wrap_next;
      if (en) begin
        r_state <= (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
        r_idx   <= w_idx_next;
        r_o     <= w_onehot ^ INACTIVE;
      end else begin
        r_o <= INACTIVE;
      end
    end
  end

  assign o    = r_o;
  assign idx  = r_idx;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_decoder_scan_nx2n.sv
// Bench: directed scenarios plus random traffic against a cycle-level behavioural model.
module tb_decoder_scan_nx2n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A/C share stimulus (N=2, DIV=4; C is active-low); B is N=3, DIV=1.
  logic       a_rst = 1'b1, a_en = 1'b0, a_mode = 1'b0, a_load = 1'b0;
  logic [1:0] a_sel = '0;
  logic [3:0] a_o, c_o;
  logic [1:0] a_idx, c_idx;
  logic       a_wrap, c_wrap;

  logic       b_rst = 1'b1, b_en = 1'b0, b_mode = 1'b0, b_load = 1'b0;
  logic [2:0] b_sel = '0;
  logic [7:0] b_o;
  logic [2:0] b_idx;
  logic       b_wrap;

  decoder_scan_nx2n #(.N(2), .DIV(4), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst(a_rst), .en(a_en), .mode(a_mode), .load(a_load), .sel(a_sel),
    .o(a_o), .idx(a_idx), .wrap(a_wrap));

  decoder_scan_nx2n #(.N(2), .DIV(4), .ACTIVE_LOW(1'b1)) dut_c (
    .clk(clk), .rst(a_rst), .en(a_en), .mode(a_mode), .load(a_load), .sel(a_sel),
    .o(c_o), .idx(c_idx), .wrap(c_wrap));

  decoder_scan_nx2n #(.N(3), .DIV(1), .ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst(b_rst), .en(b_en), .mode(b_mode), .load(b_load), .sel(b_sel),
    .o(b_o), .idx(b_idx), .wrap(b_wrap));

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_on   = 1'b0;

  // Behavioural model state: [0] = A/C, [1] = B. cnt = enabled SCAN cycles spent at idx.
  int m_idx [2] = '{0, 0};
  int m_cnt [2] = '{0, 0};
  int m_o   [2] = '{0, 0};
  bit m_scan[2] = '{0, 0};
  bit m_wrap[2] = '{0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input int k, input int lines, input int div,
                            input bit r, input bit e, input bit md, input bit ld, input int s);
    bit step;
    if (r) begin
      m_idx[k] = 0; m_cnt[k] = 0; m_scan[k] = 0; m_wrap[k] = 0; m_o[k] = 0;
    end else if (!e) begin
      m_wrap[k] = 0; m_o[k] = 0;
    end else begin
      step = m_scan[k] && (m_cnt[k] == div - 1);
      m_wrap[k] = 0;
      if (ld) begin
        m_idx[k] = s; m_cnt[k] = 0;
      end else if (step) begin
        m_wrap[k] = (m_idx[k] == lines - 1);
        m_idx[k]  = (m_idx[k] + 1) % lines;
        m_cnt[k]  = 0;
      end else if (m_scan[k]) begin
        m_cnt[k]++;
      end
      if (!m_scan[k] && md) m_cnt[k] = 0;
      m_scan[k] = md;
      m_o[k] = 1 << m_idx[k];
    end
  endtask

  always @(posedge clk) begin
    model_edge(0, 4, 4, a_rst, a_en, a_mode, a_load, int'(a_sel));
    model_edge(1, 8, 1, b_rst, b_en, b_mode, b_load, int'(b_sel));
  end

  // Every cycle: all three instances against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("a_o",    32'(a_o),    32'(m_o[0]));
      chk("a_idx",  32'(a_idx),  32'(m_idx[0]));
      chk("a_wrap", 32'(a_wrap), 32'(m_wrap[0]));
      chk("c_o",    32'(c_o),    32'((~m_o[0]) & 4'hF));
      chk("c_idx",  32'(c_idx),  32'(m_idx[0]));
      chk("c_wrap", 32'(c_wrap), 32'(m_wrap[0]));
      chk("b_o",    32'(b_o),    32'(m_o[1]));
      chk("b_idx",  32'(b_idx),  32'(m_idx[1]));
      chk("b_wrap", 32'(b_wrap), 32'(m_wrap[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wraps;
    logic [3:0] exp_o;

    // Reset held 2 cycles on both instances.
    tick(); tick();
    cmp_on = 1'b1;
    a_rst = 1'b0; b_rst = 1'b0;
    tick();
    chk("lit_reset_o", 32'(a_o), 32'h0);
    chk("lit_reset_c_o", 32'(c_o), 32'hF);
    chk("lit_reset_idx", 32'(a_idx), 32'h0);
    chk("lit_reset_wrap", 32'(a_wrap), 32'h0);

    // DIRECT load of 2, then hold.
    a_en = 1'b1; a_load = 1'b1; a_sel = 2'd2;
    tick();
    chk("lit_load_o", 32'(a_o), 32'b0100);
    chk("lit_load_idx", 32'(a_idx), 32'd2);
    a_load = 1'b0;
    tick(); tick();
    chk("lit_hold_o", 32'(a_o), 32'b0100);
    chk("lit_hold_idx", 32'(a_idx), 32'd2);

    // Back to idx 0, then SCAN walk: each line for 4 cycles, one wrap on return to 0.
    a_load = 1'b1; a_sel = 2'd0;
    tick();
    a_load = 1'b0; a_mode = 1'b1;
    wraps = 0;
    for (int k = 0; k < 17; k++) begin
      tick();
      exp_o = 4'(1 << ((k / 4) % 4));
      chk("lit_walk_o", 32'(a_o), 32'(exp_o));
      if (a_wrap) wraps++;
      if (k == 16) chk("lit_walk_wrap_at_0", 32'(a_wrap), 32'h1);
    end
    chk("lit_walk_wrap_count", 32'(wraps), 32'd1);

    // Enable freeze mid-dwell: two more dwell cycles, 3-cycle gap, then 1 left.
    tick(); tick();
    a_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("lit_gap_o", 32'(a_o), 32'h0);
      chk("lit_gap_idx", 32'(a_idx), 32'h0);
    end
    a_en = 1'b1;
    tick();
    chk("lit_resume_o", 32'(a_o), 32'b0001);
    tick();
    chk("lit_resume_step_o", 32'(a_o), 32'b0010);

    // Load of 3 on terminal count at idx 1: load wins, no wrap, step 4 cycles later.
    tick(); tick(); tick();
    a_load = 1'b1; a_sel = 2'd3;
    tick();
    chk("lit_coll_idx", 32'(a_idx), 32'd3);
    chk("lit_coll_wrap", 32'(a_wrap), 32'h0);
    a_load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("lit_coll_after_idx", 32'(a_idx), (k == 3) ? 32'd0 : 32'd3);
      chk("lit_coll_after_wrap", 32'(a_wrap), (k == 3) ? 32'h1 : 32'h0);
    end

    // N=3, DIV=1: full rotation in 8 cycles with wrap on the 8th.
    b_en = 1'b1; b_mode = 1'b1;
    tick();
    chk("lit_b_enter_idx", 32'(b_idx), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("lit_b_rot_idx", 32'(b_idx), 32'(k % 8));
      chk("lit_b_rot_wrap", 32'(b_wrap), (k == 8) ? 32'h1 : 32'h0);
    end
    tick(); tick(); tick();
    chk("lit_b_mid_idx", 32'(b_idx), 32'd3);
    b_rst = 1'b1;
    tick();
    chk("lit_b_rst_idx", 32'(b_idx), 32'd0);
    chk("lit_b_rst_o", 32'(b_o), 32'h0);
    b_rst = 1'b0;

    // Random traffic on both stimulus sets; the compare process does the checking.
    for (int k = 0; k < 600; k++) begin
      a_rst  = ($urandom_range(0, 59) == 0);
      a_en   = ($urandom_range(0, 3) != 0);
      a_mode = ($urandom_range(0, 4) != 0);
      a_load = ($urandom_range(0, 9) == 0);
      a_sel  = 2'($urandom_range(0, 3));
      b_rst  = ($urandom_range(0, 59) == 0);
      b_en   = ($urandom_range(0, 3) != 0);
      b_mode = ($urandom_range(0, 4) != 0);
      b_load = ($urandom_range(0, 9) == 0);
      b_sel  = 3'($urandom_range(0, 7));
      tick();
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
